// File: rtl/ula_mc_if.sv
// ula_mc_if: request/result bus of the multi-cycle ALU.
// master = requester/consumer side, slave = the ALU.
interface ula_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ULAcontrol;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ULAresult;
    logic             FlagZ;
    logic             FlagN;

    modport master (
        output in_valid, SrcA, SrcB, ULAcontrol, out_ready,
        input  in_ready, out_valid, ULAresult, FlagZ, FlagN
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ULAcontrol, out_ready,
        output in_ready, out_valid, ULAresult, FlagZ, FlagN
    );
endinterface

// File: rtl/ula_mc.sv
// ula_mc: ALU with a valid/ready request side and a registered result.
// Most opcodes finish in one cycle. The multiply opcode (1010) is an
// iterative shift-add that takes WIDTH cycles. The multiplier is built
// only when the macro ULA_MUL_EN is defined. Without the macro, 1010
// behaves like any undefined opcode and returns 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both 1. For a request, in_valid may rise at any time; when it is
// not accepted nothing is stored, because there is no input buffer.
// For the result, out_valid stays high and ULAresult/FlagZ/FlagN stay
// unchanged until a rising edge with out_ready=1.
module ula_mc #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    ula_mc_if.slave bus,
    output logic  busy,
    output logic  state_dbg
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] load_val;
    logic [SHW-1:0]   shamt;

    assign shamt     = bus.SrcB[SHW-1:0];
    assign state_dbg = state_q;

    // A new request is taken only in IDLE, and only when the output slot is free this cycle.
    assign bus.in_ready = rst_n && (state_q == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Single-cycle operations. Multiply is handled separately, so it falls to 0 here.
    always_comb begin
        alu_res = '0;
        case (bus.ULAcontrol)
            4'b0000: alu_res = bus.SrcA + bus.SrcB;
            4'b0001: alu_res = bus.SrcA - bus.SrcB;
            4'b0010: alu_res = bus.SrcA & bus.SrcB;
            4'b0011: alu_res = bus.SrcA | bus.SrcB;
            4'b0100: alu_res = bus.SrcA ^ bus.SrcB;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            4'b0111: alu_res = bus.SrcA << shamt;
            4'b1000: alu_res = bus.SrcA >> shamt;
            4'b1001: alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef ULA_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic             mul_start;
    logic             mul_done;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_step;

    assign mul_start = accept && (bus.ULAcontrol == OP_MUL);
    assign mul_done  = (state_q == MUL) && (cnt_q == CNT_LAST);
    // One multiplier bit per cycle; the last step's sum is the result itself.
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // FSM next state: enter MUL on an accepted multiply, leave after the final bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift-add datapath: the multiplicand moves left, the multiplier moves right.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (mul_start) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= bus.SrcA;
            mplier_q <= bus.SrcB;
        end else if (state_q == MUL) begin
            cnt_q    <= cnt_q + SHW'(1);
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign load     = (accept && !mul_start) || mul_done;
    assign load_val = mul_done ? acc_step : alu_res;
    assign busy     = (state_q == MUL);
`else
    // FSM next state: without the multiplier there is nothing to wait for.
    always_comb begin
        state_d = IDLE;
    end

    assign load     = accept;
    assign load_val = alu_res;
    assign busy     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output slot: load a new result (which may replace one being consumed), or empty it on consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.ULAresult <= '0;
            bus.FlagZ     <= 1'b0;
            bus.FlagN     <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.ULAresult <= load_val;
            bus.FlagZ     <= (load_val == '0);
            bus.FlagN     <= load_val[WIDTH-1];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ula_mc.sv
// tb_ula_mc: bench for ula_mc. A WIDTH=32 instance runs a table of
// vectors while out_ready toggles at random. Expected outputs go into a
// queue and are compared when results are handed over. A WIDTH=8
// instance runs hand-written multi-cycle sequences. The multiply checks
// follow the ULA_MUL_EN macro.
module tb_ula_mc;
    logic clk = 1'b0;
    logic rst32_n;
    logic rst8_n;
    logic busy32, busy8;
    logic state32, state8;

    int checks   = 0;
    int failures = 0;

    logic [33:0] exp_q[$];
    logic        tbl_done;

    ula_mc_if #(.WIDTH(32)) bus32();
    ula_mc_if #(.WIDTH(8))  bus8();

    ula_mc #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst32_n), .bus(bus32), .busy(busy32), .state_dbg(state32));
    ula_mc #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst8_n),  .bus(bus8),  .busy(busy8),  .state_dbg(state8));

    // Clock and reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: hold a request until it is accepted, then queue its expected output.
    task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res);
        int  n;
        logic acc;
        bus32.in_valid   = 1'b1;
        bus32.ULAcontrol = op;
        bus32.SrcA       = a;
        bus32.SrcB       = b;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus32.in_ready;
            tick();
            n++;
        end
        bus32.in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back({res[31], (res == 32'd0), res});
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout32: got in_ready=0 expected in_ready=1 within 200 cycles");
        end
    endtask

    task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.ULAcontrol = op;
        bus8.SrcA       = a;
        bus8.SrcB       = b;
    endtask

    // Scoreboard: compare every handed-over 32-bit result with the head of the queue.
    always @(negedge clk) begin
        if (rst32_n && bus32.out_valid && bus32.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out32: got result %0h expected no output", bus32.ULAresult);
            end else begin
                chk("vec32_out", {30'd0, bus32.FlagN, bus32.FlagZ, bus32.ULAresult}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        int gap;

        // 32-bit vectors: {op, a, b, expected result}
        vecs[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[2]  = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[3]  = '{4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
        vecs[4]  = '{4'b0011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[5]  = '{4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[6]  = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[7]  = '{4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[10] = '{4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[11] = '{4'b0111, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030};
        vecs[12] = '{4'b1000, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[13] = '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[14] = '{4'b1001, 32'h7FFF_FFFF, 32'h0000_001E, 32'h0000_0001};
        vecs[15] = '{4'b1011, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};
        vecs[16] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef ULA_MUL_EN
        vecs[17] = '{4'b1010, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F};
`else
        vecs[17] = '{4'b1010, 32'h0001_0003, 32'h0000_0005, 32'h0000_0000};
`endif

        tbl_done         = 1'b0;
        rst32_n          = 1'b0;
        rst8_n           = 1'b0;
        bus32.in_valid   = 1'b1;
        bus32.out_ready  = 1'b1;
        bus32.SrcA       = 32'd1;
        bus32.SrcB       = 32'd1;
        bus32.ULAcontrol = 4'b0000;
        bus8.in_valid    = 1'b1;
        bus8.out_ready   = 1'b1;
        drive8(4'b0000, 8'd1, 8'd1);

        // Reset: ready stays low while rst_n=0, then the reset state is checked.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready8", {63'd0, bus8.in_ready}, 64'd0);
        chk("rst_in_ready32", {63'd0, bus32.in_ready}, 64'd0);
        chk("rst_state8", {56'd0, bus8.ULAresult, bus8.out_valid, bus8.FlagZ, bus8.FlagN, busy8, state8},
            64'd0);
        chk("rst_state32", {27'd0, bus32.ULAresult, bus32.out_valid, bus32.FlagZ, bus32.FlagN, busy32, state32},
            64'd0);
        tick();
        bus32.in_valid = 1'b0;
        bus8.in_valid  = 1'b0;
        rst32_n        = 1'b1;
        rst8_n         = 1'b1;
        tick();

        // Table vectors on the 32-bit instance, with out_ready toggling at random.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    send32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
                    gap = $urandom_range(0, 2);
                    repeat (gap) tick();
                end
                tbl_done = 1'b1;
            end
            begin
                while (!tbl_done) begin
                    tick();
                    bus32.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus32.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain32_pending", 64'(exp_q.size()), 64'd0);

        // 8-bit add that wraps to zero, taken with out_ready=1.
        drive8(4'b0000, 8'hFF, 8'h01);
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("add_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("add_wrap", {53'd0, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN}, {53'd0, 1'b1, 8'h00, 2'b10});
        tick();
        @(negedge clk);
        chk("consumed_clear", {63'd0, bus8.out_valid}, 64'd0);
        tick();

        // Stall: an OR result held while the next request waits.
        bus8.out_ready = 1'b0;
        drive8(4'b0011, 8'h50, 8'h0A);
        bus8.in_valid = 1'b1;
        tick();
        drive8(4'b0000, 8'h01, 8'h01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {52'd0, bus8.in_ready, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN},
                {52'd0, 1'b0, 1'b1, 8'h5A, 2'b00});
            tick();
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", {63'd0, bus8.in_ready}, 64'd1);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_next_result", {55'd0, bus8.out_valid, bus8.ULAresult}, {55'd0, 1'b1, 8'h02});
        tick();

`ifndef ULA_MUL_EN
        // Without the multiplier, 1010 returns 0 one cycle later and never sets busy.
        drive8(4'b1010, 8'd5, 8'd3);
        bus8.in_valid = 1'b1;
        @(negedge clk);
        chk("nomul_busy_pre", {63'd0, busy8}, 64'd0);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("nomul_result", {52'd0, busy8, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN},
            {52'd0, 1'b0, 1'b1, 8'h00, 2'b10});
        tick();
        @(negedge clk);
        chk("nomul_busy_post", {62'd0, busy8, state8}, 64'd0);
        tick();
`endif

        // Back-to-back: one result per cycle with out_ready held at 1.
        drive8(4'b0001, 8'h00, 8'h01);
        bus8.in_valid = 1'b1;
        tick();
        drive8(4'b0010, 8'hF0, 8'h3C);
        @(negedge clk);
        chk("b2b_first", {52'd0, bus8.in_ready, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN},
            {52'd0, 1'b1, 1'b1, 8'hFF, 2'b01});
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second", {53'd0, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN},
            {53'd0, 1'b1, 8'h30, 2'b00});
        tick();
        @(negedge clk);
        chk("b2b_clear", {63'd0, bus8.out_valid}, 64'd0);
        tick();

`ifdef ULA_MUL_EN
        // Multiply 13*11: busy for 8 cycles while requests are refused, then 8'h8F.
        drive8(4'b1010, 8'd13, 8'd11);
        bus8.in_valid = 1'b1;
        @(negedge clk);
        chk("mul_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        tick();
        drive8(4'b0000, 8'd1, 8'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy", {61'd0, busy8, bus8.in_ready, bus8.out_valid}, {61'd0, 3'b100});
            tick();
        end
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("mul_result", {52'd0, busy8, bus8.out_valid, bus8.ULAresult, bus8.FlagZ, bus8.FlagN},
            {52'd0, 1'b0, 1'b1, 8'h8F, 2'b01});
        tick();

        // Reset in the third cycle of a multiply: aborted, no result afterwards.
        drive8(4'b1010, 8'd13, 8'd11);
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        rst8_n = 1'b0;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_mul_in_ready", {63'd0, bus8.in_ready}, 64'd0);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mul_state", {54'd0, busy8, bus8.out_valid, bus8.ULAresult}, 64'd0);
        tick();
        rst8_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_mul_no_result", {62'd0, bus8.out_valid, busy8}, 64'd0);
            tick();
        end
`endif

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
